// File: rtl/exe_imul_pkg.sv
// Shared types for the RV64M multiply unit: issue/writeback packets, op decode
// and the partial-product bundle passed between the ex0 and ex1 stages.
package exe_imul_pkg;

  localparam int MUL_RESULT_W = 64;
  localparam int ROBID_W      = 6;
  localparam int PDST_W       = 7;
  localparam int SIMID_W      = 32;

  localparam logic [7:0] UOP_MUL    = 8'h30;
  localparam logic [7:0] UOP_MULH   = 8'h31;
  localparam logic [7:0] UOP_MULHSU = 8'h32;
  localparam logic [7:0] UOP_MULHU  = 8'h33;
  localparam logic [7:0] UOP_MULW   = 8'h38;

  typedef enum logic [2:0] {
    MUL_NONE   = 3'd0,
    MUL_MUL    = 3'd1,
    MUL_MULH   = 3'd2,
    MUL_MULHSU = 3'd3,
    MUL_MULHU  = 3'd4,
    MUL_MULW   = 3'd5
  } t_mul_op;

  typedef enum logic [1:0] {
    OP_INVALID = 2'd0,
    OP_REG     = 2'd1,
    OP_ZERO    = 2'd2,
    OP_IMM     = 2'd3
  } t_optype;

  typedef struct packed {
    t_optype    optype;
    logic [4:0] idx;
  } t_opnd;

  typedef struct packed {
    logic [7:0]         uopc;
    t_opnd              dst;
    logic [SIMID_W-1:0] simid;
  } t_uinstr;

  typedef struct packed {
    t_uinstr                 uinstr;
    logic [ROBID_W-1:0]      robid;
    logic [PDST_W-1:0]       pdst;
    logic [MUL_RESULT_W-1:0] src1_val;
    logic [MUL_RESULT_W-1:0] src2_val;
  } t_uinstr_iss;

  typedef struct packed {
    logic [PDST_W-1:0]       pdst;
    logic [MUL_RESULT_W-1:0] data;
  } t_prf_wr_pkt;

  typedef struct packed {
    logic [ROBID_W-1:0] robid;
    logic [SIMID_W-1:0] simid;
  } t_rob_cmpl_pkt;

  // Per-op bookkeeping carried alongside the datapath through ex0/ex1.
  typedef struct packed {
    t_mul_op            op;
    t_optype            dst_optype;
    logic [PDST_W-1:0]  pdst;
    logic [ROBID_W-1:0] robid;
    logic [SIMID_W-1:0] simid;
  } t_mul_meta;

  typedef struct packed {
    t_prf_wr_pkt   prf;
    t_rob_cmpl_pkt cmpl;
  } t_mul_wb;

  // 33x33 signed partial products, each held in 66 bits.
  typedef struct packed {
    logic [65:0] hh;
    logic [65:0] hl;
    logic [65:0] lh;
    logic [65:0] ll;
  } t_pp;

  function automatic t_mul_op f_decode_mul_op(input t_uinstr uinstr);
    t_mul_op op;
    case (uinstr.uopc)
      UOP_MUL:    op = MUL_MUL;
      UOP_MULH:   op = MUL_MULH;
      UOP_MULHSU: op = MUL_MULHSU;
      UOP_MULHU:  op = MUL_MULHU;
      UOP_MULW:   op = MUL_MULW;
      default:    op = MUL_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/exe_imul_chk.sv
// Protocol checker for the multiply unit: flags issue of an op the decoder
// does not recognise.
module exe_imul_chk
  import exe_imul_pkg::*;
#(
  parameter string EU_NAME = ""
) (
  input logic    clk,
  input logic    reset,
  input logic    iss_rs2,
  input t_mul_op iss_op
);

  a_known_op: assert property (@(posedge clk) disable iff (!reset)
    iss_rs2 |-> (iss_op != MUL_NONE))
    else $error("%s: unknown multiply op issued", EU_NAME);

endmodule

// File: rtl/exe_imul_core.sv
// Pure combinational multiply datapath: splits two 65b signed operands into
// 33b halves to form partial products, and sums registered partials into 128b.
module exe_imul_core
  import exe_imul_pkg::*;
(
  input  logic [64:0]  opa,
  input  logic [64:0]  opb,
  output t_pp          pp,
  input  t_pp          pp_sum,
  output logic [127:0] prod
);

  logic [65:0] a_hi_s, a_lo_s, b_hi_s, b_lo_s;

  // Upper halves are signed (bit 64 is the sign), lower halves are plain magnitudes;
  // with explicit 66b extension the modular products equal the signed ones.
  always_comb begin
    a_hi_s = {{33{opa[64]}}, opa[64:32]};
    a_lo_s = {34'd0, opa[31:0]};
    b_hi_s = {{33{opb[64]}}, opb[64:32]};
    b_lo_s = {34'd0, opb[31:0]};
    pp.hh  = a_hi_s * b_hi_s;
    pp.hl  = a_hi_s * b_lo_s;
    pp.lh  = a_lo_s * b_hi_s;
    pp.ll  = a_lo_s * b_lo_s;
  end

  logic [127:0] e_hh_s, e_hl_s, e_lh_s, e_ll_s;

  // Only the low 128 bits of the full 130b product are ever consumed.
  always_comb begin
    e_hh_s = {{62{pp_sum.hh[65]}}, pp_sum.hh};
    e_hl_s = {{62{pp_sum.hl[65]}}, pp_sum.hl};
    e_lh_s = {{62{pp_sum.lh[65]}}, pp_sum.lh};
    e_ll_s = {{62{pp_sum.ll[65]}}, pp_sum.ll};
    prod   = (e_hh_s << 64) + (e_hl_s << 32) + (e_lh_s << 32) + e_ll_s;
  end

endmodule

// File: rtl/exe_imul.sv
// Pipelined RV64M multiply unit: ex0 operand prep + partial products, ex1 sum,
// ex2 result select, then optional pure-delay stages up to the writeback register.
module exe_imul
  import exe_imul_pkg::*;
#(
  parameter int    NUM_MUL_STAGES = 3,
  parameter string EU_NAME        = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          nuke_rb1,
  input  logic          iss_rs2,
  input  t_uinstr_iss   iss_pkt_rs2,
  output logic          iprf_wr_en_ex,
  output t_prf_wr_pkt   iprf_wr_pkt_ex,
  output logic          rob_cmpl_ex,
  output t_rob_cmpl_pkt rob_cmpl_pkt_ex
);

  localparam int LAST = NUM_MUL_STAGES - 1;

  t_mul_op      iss_op_s;
  logic [63:0]  src1_s, src2_s;
  logic [64:0]  opa_s, opb_s;
  t_mul_meta    meta_s, meta0_r, meta1_r;
  t_pp          pp_s, pp0_r;
  logic [127:0] prod_s, prod1_r;
  logic         v0_r, v1_r;

  assign iss_op_s = f_decode_mul_op(iss_pkt_rs2.uinstr);
  assign src1_s   = iss_pkt_rs2.src1_val;
  assign src2_s   = iss_pkt_rs2.src2_val;

  // Operand extension to 65b according to the signedness of each op.
  always_comb begin
    opa_s = {1'b0, src1_s};
    opb_s = {1'b0, src2_s};
    case (iss_op_s)
      MUL_MULH: begin
        opa_s = {src1_s[63], src1_s};
        opb_s = {src2_s[63], src2_s};
      end
      MUL_MULHSU: begin
        opa_s = {src1_s[63], src1_s};
        opb_s = {1'b0, src2_s};
      end
      MUL_MULW: begin
        opa_s = {{33{src1_s[31]}}, src1_s[31:0]};
        opb_s = {{33{src2_s[31]}}, src2_s[31:0]};
      end
      default: begin
        opa_s = {1'b0, src1_s};
        opb_s = {1'b0, src2_s};
      end
    endcase
  end

  // Bookkeeping that travels with the op.
  always_comb begin
    meta_s            = '0;
    meta_s.op         = iss_op_s;
    meta_s.dst_optype = iss_pkt_rs2.uinstr.dst.optype;
    meta_s.pdst       = iss_pkt_rs2.pdst;
    meta_s.robid      = iss_pkt_rs2.robid;
    meta_s.simid      = iss_pkt_rs2.uinstr.simid;
  end

  exe_imul_core u_core (
    .opa    (opa_s),
    .opb    (opb_s),
    .pp     (pp_s),
    .pp_sum (pp0_r),
    .prod   (prod_s)
  );

  exe_imul_chk #(.EU_NAME(EU_NAME)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .iss_rs2 (iss_rs2),
    .iss_op  (iss_op_s)
  );

  // ex0/ex1 valids; a flush kills both and drops a same-cycle issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_r <= 1'b0;
      v1_r <= 1'b0;
    end else begin
      v0_r <= iss_rs2 & ~nuke_rb1;
      v1_r <= v0_r & ~nuke_rb1;
    end
  end

  // ex0/ex1 payload staging.
  always_ff @(posedge clk) begin
    meta0_r <= meta_s;
    pp0_r   <= pp_s;
    meta1_r <= meta0_r;
    prod1_r <= prod_s;
  end

  t_mul_wb wb_sel_s;

  // Result select from the 128b product; undecoded ops write zero.
  always_comb begin
    wb_sel_s            = '0;
    wb_sel_s.prf.pdst   = meta1_r.pdst;
    wb_sel_s.cmpl.robid = meta1_r.robid;
    wb_sel_s.cmpl.simid = meta1_r.simid;
    case (meta1_r.op)
      MUL_MUL:                        wb_sel_s.prf.data = prod1_r[63:0];
      MUL_MULH, MUL_MULHSU, MUL_MULHU: wb_sel_s.prf.data = prod1_r[127:64];
      MUL_MULW:                       wb_sel_s.prf.data = {{32{prod1_r[31]}}, prod1_r[31:0]};
      default:                        wb_sel_s.prf.data = '0;
    endcase
  end

  logic [LAST:2] cmpl_v_r, wr_v_r, cmpl_src_s, wr_src_s, keep_s;
  t_mul_wb       wb_r     [2:LAST];
  t_mul_wb       wb_src_s [2:LAST];

  // The op entering the writeback register is already committed, so a flush
  // spares only that final stage.
  always_comb begin
    cmpl_src_s    = '0;
    wr_src_s      = '0;
    wb_src_s      = '{default: '0};
    cmpl_src_s[2] = v1_r;
    wr_src_s[2]   = v1_r & (meta1_r.dst_optype == OP_REG);
    wb_src_s[2]   = wb_sel_s;
    for (int k = 3; k <= LAST; k++) begin
      cmpl_src_s[k] = cmpl_v_r[k-1];
      wr_src_s[k]   = wr_v_r[k-1];
      wb_src_s[k]   = wb_r[k-1];
    end
    keep_s       = nuke_rb1 ? '0 : '1;
    keep_s[LAST] = 1'b1;
  end

  // Select/delay stage valids.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmpl_v_r <= '0;
      wr_v_r   <= '0;
    end else begin
      cmpl_v_r <= cmpl_src_s & keep_s;
      wr_v_r   <= wr_src_s & keep_s;
    end
  end

  // Select/delay stage payloads.
  always_ff @(posedge clk) begin
    for (int k = 2; k <= LAST; k++) begin
      wb_r[k] <= wb_src_s[k];
    end
  end

  assign rob_cmpl_ex     = cmpl_v_r[LAST];
  assign iprf_wr_en_ex   = wr_v_r[LAST];
  assign iprf_wr_pkt_ex  = wb_r[LAST].prf;
  assign rob_cmpl_pkt_ex = wb_r[LAST].cmpl;

endmodule

// File: tb/tb_exe_imul.sv
// Self-checking bench for exe_imul: fixed vector table, hand-written flush /
// reset / dst-type sequences, and randomized traffic against a cycle-log model.
module tb_exe_imul;
  import exe_imul_pkg::*;

  localparam int LAT  = 3;
  localparam int HMAX = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          nuke_rb1 = 1'b0;
  logic          iss_rs2 = 1'b0;
  t_uinstr_iss   iss_pkt_rs2 = '0;
  logic          iprf_wr_en_ex;
  t_prf_wr_pkt   iprf_wr_pkt_ex;
  logic          rob_cmpl_ex;
  t_rob_cmpl_pkt rob_cmpl_pkt_ex;

  exe_imul #(.NUM_MUL_STAGES(LAT), .EU_NAME("imul0")) dut (
    .clk             (clk),
    .reset           (reset),
    .nuke_rb1        (nuke_rb1),
    .iss_rs2         (iss_rs2),
    .iss_pkt_rs2     (iss_pkt_rs2),
    .iprf_wr_en_ex   (iprf_wr_en_ex),
    .iprf_wr_pkt_ex  (iprf_wr_pkt_ex),
    .rob_cmpl_ex     (rob_cmpl_ex),
    .rob_cmpl_pkt_ex (rob_cmpl_pkt_ex)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cmpl_seen = 0;
  int simid_ctr = 100;
  t_mul_op cur_op = MUL_MUL;

  bit          log_iss  [HMAX];
  bit          log_nuke [HMAX];
  bit          log_rst  [HMAX];
  t_mul_op     log_op   [HMAX];
  t_uinstr_iss log_pkt  [HMAX];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64/128-bit arithmetic following the RV64M definitions.
  function automatic logic [63:0] ref_mul(input t_mul_op op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] xa, xb, p;
    logic [31:0]  w;
    case (op)
      MUL_MUL:    return a * b;
      MUL_MULH:   begin xa = {{64{a[63]}}, a}; xb = {{64{b[63]}}, b}; end
      MUL_MULHSU: begin xa = {{64{a[63]}}, a}; xb = {64'd0, b}; end
      MUL_MULHU:  begin xa = {64'd0, a}; xb = {64'd0, b}; end
      MUL_MULW: begin
        w = a[31:0] * b[31:0];
        return {{32{w[31]}}, w};
      end
      default: return 64'd0;
    endcase
    p = xa * xb;
    return p[127:64];
  endfunction

  function automatic logic [7:0] uop_of(input t_mul_op op);
    case (op)
      MUL_MUL:    return UOP_MUL;
      MUL_MULH:   return UOP_MULH;
      MUL_MULHSU: return UOP_MULHSU;
      MUL_MULHU:  return UOP_MULHU;
      MUL_MULW:   return UOP_MULW;
      default:    return 8'hFF;
    endcase
  endfunction

  // An op issued in cycle s writes back in cycle s+LAT unless flushed in
  // cycle s or s+1, or reset was low at any point since issue.
  function automatic bit exp_valid(input int t);
    int s;
    if (t < LAT || !reset) return 1'b0;
    s = t - LAT;
    return log_iss[s] && !log_nuke[s] && !log_nuke[s+1] &&
           log_rst[s] && log_rst[s+1] && log_rst[s+2];
  endfunction

  always @(posedge clk) begin
    if (cyc >= HMAX - 1) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HMAX - 1);
      $fatal(1);
    end
    log_iss[cyc]  <= iss_rs2;
    log_nuke[cyc] <= nuke_rb1;
    log_rst[cyc]  <= reset;
    log_op[cyc]   <= cur_op;
    log_pkt[cyc]  <= iss_pkt_rs2;
    cyc           <= cyc + 1;
  end

  always @(negedge clk) begin
    t_uinstr_iss p;
    bit          ev, ewr;
    ev = exp_valid(cyc);
    chk("rob_cmpl", {63'd0, rob_cmpl_ex}, {63'd0, ev});
    if (ev) begin
      p   = log_pkt[cyc-LAT];
      ewr = (p.uinstr.dst.optype == OP_REG);
      chk("robid", {58'd0, rob_cmpl_pkt_ex.robid}, {58'd0, p.robid});
      chk("simid", {32'd0, rob_cmpl_pkt_ex.simid}, {32'd0, p.uinstr.simid});
      chk("wr_en", {63'd0, iprf_wr_en_ex}, {63'd0, ewr});
      if (ewr) begin
        chk("pdst", {57'd0, iprf_wr_pkt_ex.pdst}, {57'd0, p.pdst});
        chk("data", iprf_wr_pkt_ex.data, ref_mul(log_op[cyc-LAT], p.src1_val, p.src2_val));
      end
    end else begin
      chk("wr_en_idle", {63'd0, iprf_wr_en_ex}, 64'd0);
    end
    if (rob_cmpl_ex) cmpl_seen++;
  end

  // Called at posedge+1; holds the inputs for exactly one cycle.
  task automatic drive(input bit v, input t_mul_op op, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] robid, input t_optype ot, input bit nk);
    t_uinstr_iss p;
    p                    = '0;
    p.uinstr.uopc        = uop_of(op);
    p.uinstr.dst.optype  = ot;
    p.uinstr.dst.idx     = robid[4:0];
    p.uinstr.simid       = simid_ctr;
    p.robid              = robid;
    p.pdst               = {1'b1, robid};
    p.src1_val           = a;
    p.src2_val           = b;
    simid_ctr++;
    iss_pkt_rs2 = p;
    cur_op      = op;
    iss_rs2     = v;
    nuke_rb1    = nk;
    @(posedge clk);
    #1;
    iss_rs2  = 1'b0;
    nuke_rb1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return {32'd0, 32'($urandom)};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  typedef struct {
    t_mul_op     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int base;
    vecs[0] = '{MUL_MUL,    64'h7,                   64'h6,                   64'h2A};
    vecs[1] = '{MUL_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'h2,                   64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{MUL_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h2,                   64'h1};
    vecs[3] = '{MUL_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,                   64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{MUL_MULW,   64'h0000_0000_8000_0000, 64'h2,                   64'h0};
    vecs[5] = '{MUL_MULW,   64'h0000_0000_4000_0000, 64'h2,                   64'hFFFF_FFFF_8000_0000};
    vecs[6] = '{MUL_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
    vecs[7] = '{MUL_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[8] = '{MUL_MULHSU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    vecs[9] = '{MUL_MULW,   64'hFFFF_FFFF_7FFF_FFFF, 64'h2,                   64'hFFFF_FFFF_FFFF_FFFE};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmpl", {63'd0, rob_cmpl_ex}, 64'd0);
    chk("reset_wr_en", {63'd0, iprf_wr_en_ex}, 64'd0);
    reset = 1'b1;

    // Isolated issues with table-fixed results at issue+LAT.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 6'(i), OP_REG, 1'b0);
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
      chk("vec_wr_en", {63'd0, iprf_wr_en_ex}, 64'd1);
      chk("vec_data", iprf_wr_pkt_ex.data, vecs[i].exp);
      chk("vec_robid", {58'd0, rob_cmpl_pkt_ex.robid}, 64'(i));
      @(posedge clk);
      #1;
    end

    // Back-to-back issues complete back-to-back in order.
    base = cmpl_seen;
    for (int r = 0; r < 8; r++) begin
      drive(1'b1, t_mul_op'($urandom_range(1, 5)), rnd_opnd(), rnd_opnd(), 6'(r), OP_REG, 1'b0);
    end
    idle(LAT + 2);
    chk("b2b_count", 64'(cmpl_seen - base), 64'd8);

    // Flush in the third issue cycle: only the oldest op survives.
    base = cmpl_seen;
    drive(1'b1, MUL_MUL, 64'd3, 64'd5, 6'd1, OP_REG, 1'b0);
    drive(1'b1, MUL_MUL, 64'd4, 64'd5, 6'd2, OP_REG, 1'b0);
    drive(1'b1, MUL_MUL, 64'd6, 64'd5, 6'd3, OP_REG, 1'b1);
    idle(6);
    chk("flush_count", 64'(cmpl_seen - base), 64'd1);

    // Non-register destination: completion without PRF write.
    drive(1'b1, MUL_MUL, 64'd9, 64'd9, 6'd20, OP_ZERO, 1'b0);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("zero_cmpl", {63'd0, rob_cmpl_ex}, 64'd1);
    chk("zero_wr_en", {63'd0, iprf_wr_en_ex}, 64'd0);
    @(posedge clk);
    #1;

    // Reset pulse while three ops are in flight.
    base = cmpl_seen;
    drive(1'b1, MUL_MULH, 64'd11, 64'd12, 6'd30, OP_REG, 1'b0);
    drive(1'b1, MUL_MULH, 64'd13, 64'd14, 6'd31, OP_REG, 1'b0);
    drive(1'b1, MUL_MULH, 64'd15, 64'd16, 6'd32, OP_REG, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_cmpl", {63'd0, rob_cmpl_ex}, 64'd0);
    idle(2);
    reset = 1'b1;
    idle(6);
    chk("midrst_count", 64'(cmpl_seen - base), 64'd0);

    // Random traffic with occasional flushes; checked by the cycle monitor.
    for (int n = 0; n < 400; n++) begin
      t_optype ot;
      case ($urandom_range(0, 7))
        0:       ot = OP_ZERO;
        1:       ot = OP_INVALID;
        default: ot = OP_REG;
      endcase
      drive(($urandom_range(0, 3) != 0), t_mul_op'($urandom_range(1, 5)), rnd_opnd(), rnd_opnd(),
            6'($urandom), ot, ($urandom_range(0, 15) == 0));
    end
    idle(LAT + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
